// File: rtl/interpolating_lut_loader.sv
// interpolating_lut_loader: staging RAM plus stream engine that programs the interpolating LUT core.
// Latency: 3 cycles per word minimum (fetch, latch, send); one registered RAM read per word.
// Backpressure: prog_dout/prog_dout_valid are held stable until prog_dout_ready; host writes and
//   start pulses are ignored while busy.
//
// Ports:
//   clk, reset (sync, active-high), enable (0 acts as reset)
//   host_wr_addr/host_wr_data/host_wr_en : staging RAM write port
//   start                                : begin a load (accepted only when not busy)
//   busy / done / error                  : status; done and error are sticky until the next load
//   prog_dout/prog_dout_valid/prog_dout_ready : word stream to the core's lut_prog_din
//   prog_core_done                       : core reports the table was taken
// Optional feature: define LUT_LOADER_CHECKSUM_EN to add prog_checksum, the running sum of the
//   words handshaked during the current load.

module interpolating_lut_loader #(
    parameter int G_ADDR_WIDTH   = 10,
    parameter int G_DWIDTH       = 24,
    parameter int G_DONE_TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [G_ADDR_WIDTH-1:0] host_wr_addr,
    input  logic [G_DWIDTH-1:0]     host_wr_data,
    input  logic                    host_wr_en,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [G_DWIDTH-1:0]     prog_dout,
    output logic                    prog_dout_valid,
    input  logic                    prog_dout_ready,
    input  logic                    prog_core_done
`ifdef LUT_LOADER_CHECKSUM_EN
    ,
    output logic [G_DWIDTH+G_ADDR_WIDTH-1:0] prog_checksum
`endif
);

    localparam int N  = 1 << G_ADDR_WIDTH;
    localparam int TW = $clog2(G_DONE_TIMEOUT + 1);
    localparam logic [TW-1:0]           TO_LAST   = TW'(G_DONE_TIMEOUT - 1);
    localparam logic [G_ADDR_WIDTH-1:0] ADDR_LAST = G_ADDR_WIDTH'(N - 1);

    typedef enum logic [2:0] {
        SM_IDLE,
        SM_FETCH,
        SM_LATCH,
        SM_SEND,
        SM_WAIT_DONE,
        SM_DONE,
        SM_ERROR
    } state_t;

    state_t                  state;
    logic                    rst;
    logic [G_ADDR_WIDTH-1:0] addr;
    logic [TW-1:0]           to_cnt;
    logic [G_DWIDTH-1:0]     mem [N];
    logic [G_DWIDTH-1:0]     ram_q;

    assign rst = reset | ~enable;

    // Staging RAM: contents survive reset. Writes are locked out for the whole load so the
    // streamed table is a consistent snapshot.
    always_ff @(posedge clk) begin
        if (host_wr_en && !busy) begin
            mem[host_wr_addr] <= host_wr_data;
        end
        if (state == SM_FETCH) begin
            ram_q <= mem[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= SM_IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
            prog_dout       <= '0;
            prog_dout_valid <= 1'b0;
            addr            <= '0;
            to_cnt          <= '0;
`ifdef LUT_LOADER_CHECKSUM_EN
            prog_checksum   <= '0;
`endif
        end else begin
            case (state)
                // DONE/ERROR differ from IDLE only in the sticky flags they leave visible.
                SM_IDLE, SM_DONE, SM_ERROR: begin
                    if (start) begin
                        done  <= 1'b0;
                        error <= 1'b0;
                        busy  <= 1'b1;
                        addr  <= '0;
`ifdef LUT_LOADER_CHECKSUM_EN
                        prog_checksum <= '0;
`endif
                        state <= SM_FETCH;
                    end
                end
                SM_FETCH: begin
                    // RAM read of addr is issued this cycle; data is in ram_q next cycle.
                    state <= SM_LATCH;
                end
                SM_LATCH: begin
                    prog_dout       <= ram_q;
                    prog_dout_valid <= 1'b1;
                    state           <= SM_SEND;
                end
                SM_SEND: begin
                    if (prog_dout_ready) begin
                        prog_dout_valid <= 1'b0;
`ifdef LUT_LOADER_CHECKSUM_EN
                        prog_checksum <= prog_checksum + (G_DWIDTH+G_ADDR_WIDTH)'(prog_dout);
`endif
                        if (addr == ADDR_LAST) begin
                            to_cnt <= '0;
                            state  <= SM_WAIT_DONE;
                        end else begin
                            addr  <= addr + 1'b1;
                            state <= SM_FETCH;
                        end
                    end
                end
                SM_WAIT_DONE: begin
                    // done wins over the timeout on the final counted cycle.
                    if (prog_core_done) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= SM_DONE;
                    end else if (to_cnt == TO_LAST) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= SM_ERROR;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= SM_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interpolating_lut_loader.sv
module tb_interpolating_lut_loader;

    localparam int AW = 2;
    localparam int DW = 8;
    localparam int TO = 8;
    localparam int N  = 1 << AW;

    logic          clk = 1'b0;
    logic          reset, enable, host_wr_en, start, prog_dout_ready, prog_core_done;
    logic [AW-1:0] host_wr_addr;
    logic [DW-1:0] host_wr_data;
    logic          busy, done, error, prog_dout_valid;
    logic [DW-1:0] prog_dout;
`ifdef LUT_LOADER_CHECKSUM_EN
    logic [DW+AW-1:0] prog_checksum;
`endif

    interpolating_lut_loader #(
        .G_ADDR_WIDTH(AW), .G_DWIDTH(DW), .G_DONE_TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data), .host_wr_en(host_wr_en),
        .start(start), .busy(busy), .done(done), .error(error),
        .prog_dout(prog_dout), .prog_dout_valid(prog_dout_valid),
        .prog_dout_ready(prog_dout_ready), .prog_core_done(prog_core_done)
`ifdef LUT_LOADER_CHECKSUM_EN
        , .prog_checksum(prog_checksum)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: host view of the staging table and expected stream of the current load.
    logic [DW-1:0] ram_m [N];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] got   [$];
    int            exp_sum;
    int            cyc = 0;
    int            hs_cyc = 0;
    int            err_cyc = 0;
    int            rdy_mode = 0;
    logic          err_prev = 1'b0;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] stall_dat;

    always @(posedge clk) cyc++;

    // Monitor: records handshakes and checks that a stalled word stays put.
    always @(negedge clk) begin
        if (stall_prev) begin
            check("hold_valid", prog_dout_valid, 1);
            check("hold_data", prog_dout, stall_dat);
        end
        stall_prev = prog_dout_valid && !prog_dout_ready && !reset && enable;
        stall_dat  = prog_dout;
        if (prog_dout_valid && prog_dout_ready && !reset && enable) begin
            got.push_back(prog_dout);
            hs_cyc = cyc;
        end
        if (error && !err_prev) err_cyc = cyc;
        err_prev = error;
    end

    // Ready driver: 0 = always ready, 1 = toggling with 3-cycle stalls, 2 = random.
    initial begin
        int stall_left = 0;
        prog_dout_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: begin
                    if (stall_left > 0) begin
                        prog_dout_ready = 1'b0;
                        stall_left--;
                    end else if ($urandom_range(0, 4) == 0) begin
                        prog_dout_ready = 1'b0;
                        stall_left = 2;
                    end else begin
                        prog_dout_ready = ~prog_dout_ready;
                    end
                end
                2:       prog_dout_ready = 1'($urandom_range(0, 1));
                default: prog_dout_ready = 1'b1;
            endcase
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic host_write(input int a, input int d, input bit commit);
        host_wr_addr = AW'(a);
        host_wr_data = DW'(d);
        host_wr_en   = 1'b1;
        tick();
        host_wr_en   = 1'b0;
        if (commit) ram_m[a] = DW'(d);
    endtask

    task automatic start_load(input bit wr_too, input int a, input int d);
        got.delete();
        exp_q.delete();
        if (wr_too) begin
            host_wr_addr = AW'(a);
            host_wr_data = DW'(d);
            host_wr_en   = 1'b1;
            ram_m[a]     = DW'(d);
        end
        exp_sum = 0;
        for (int i = 0; i < N; i++) begin
            exp_q.push_back(ram_m[i]);
            exp_sum += int'(ram_m[i]);
        end
        start = 1'b1;
        tick();
        start      = 1'b0;
        host_wr_en = 1'b0;
        check("start_busy", busy, 1);
        check("start_done", done, 0);
        check("start_error", error, 0);
`ifdef LUT_LOADER_CHECKSUM_EN
        check("start_checksum", prog_checksum, 0);
`endif
    endtask

    task automatic wait_words(input int n);
        int t = 0;
        while (got.size() < n && t < 300) begin
            tick();
            t++;
        end
        check("words_arrived", got.size() >= n, 1);
    endtask

    // Returns at #1 after the last handshake edge; c is the timeout-counter value during
    // which prog_core_done is raised (c >= TO+4: never raised).
    task automatic end_load(input int c);
        int t = 0;
        check("wait_busy", busy, 1);
        check("wait_valid", prog_dout_valid, 0);
        if (c < TO + 4) begin
            tick(c);
            prog_core_done = 1'b1;
            tick();
            prog_core_done = 1'b0;
        end
        while (!done && !error && t < 40) begin
            tick();
            t++;
        end
        tick(2);
        check("end_done", done, c < TO);
        check("end_error", error, c >= TO);
        check("end_busy", busy, 0);
        if (c >= TO) check("err_latency", err_cyc - (hs_cyc + 1), TO);
        check("n_words", got.size(), N);
        for (int i = 0; i < N; i++) begin
            if (i < got.size()) check($sformatf("word%0d", i), got[i], exp_q[i]);
        end
`ifdef LUT_LOADER_CHECKSUM_EN
        check("checksum", prog_checksum, exp_sum);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; enable = 1'b1; host_wr_en = 1'b0; start = 1'b0;
        prog_core_done = 1'b0; host_wr_addr = '0; host_wr_data = '0;
        tick(3);
        reset = 1'b0;
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_valid", prog_dout_valid, 0);
        check("rst_dout", prog_dout, 0);

        // Basic load with always-ready sink.
        for (int i = 0; i < N; i++) host_write(i, 8'h11 * (i + 1), 1);
        start_load(0, 0, 0);
        wait_words(N);
        end_load(2);
`ifdef LUT_LOADER_CHECKSUM_EN
        check("checksum_aa", prog_checksum, 10'h0AA);
`endif

        // Backpressure: toggling ready with stalls.
        rdy_mode = 1;
        start_load(0, 0, 0);
        wait_words(N);
        end_load(2);
        rdy_mode = 0;

        // Timeout, and the done/timeout boundary on either side.
        start_load(0, 0, 0);
        wait_words(N);
        end_load(100);
        start_load(0, 0, 0);
        wait_words(N);
        end_load(TO - 1);
        start_load(0, 0, 0);
        wait_words(N);
        end_load(TO);

        // Host write and second start during a load are ignored.
        start_load(0, 0, 0);
        tick(2);
        host_write(1, 8'hFF, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_2nd_start", busy, 1);
        wait_words(N);
        end_load(1);
        start_load(0, 0, 0);
        wait_words(N);
        end_load(0);
        check("addr1_kept", got[1], 8'h22);

        // Reset after the second handshake aborts the load.
        start_load(0, 0, 0);
        wait_words(2);
        reset = 1'b1;
        tick();
        check("abort_valid", prog_dout_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        reset = 1'b0;
        tick(6);
        check("abort_words", got.size(), 2);
        start_load(0, 0, 0);
        wait_words(N);
        end_load(3);

        // enable=0 behaves like reset.
        start_load(0, 0, 0);
        wait_words(1);
        enable = 1'b0;
        tick();
        check("en_valid", prog_dout_valid, 0);
        check("en_busy", busy, 0);
        check("en_done", done, 0);
        enable = 1'b1;
        tick(6);
        check("en_words", got.size(), 1);

        // Randomized loads, including write+start in the same idle cycle.
        for (int it = 0; it < 10; it++) begin
            for (int i = 0; i < N; i++) host_write(i, int'($urandom_range(0, 255)), 1);
            rdy_mode = int'($urandom_range(0, 2));
            start_load(1'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)),
                       int'($urandom_range(0, 255)));
            wait_words(N);
            end_load(int'($urandom_range(0, TO + 1)));
        end
        rdy_mode = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
